imem_loader_ctrl: RTL and testbench
===================================

# imem_loader_ctrl

Boot and program-load controller for the pipelined RISC-V core. It holds the core in reset and accepts a framed byte stream from a host link. It assembles little-endian 32-bit words, writes them into instruction memory through a dedicated write port, and verifies an XOR checksum. On success it releases the core to run; on failure it keeps the core in reset and flags an error.

## Interface
- P_ADDR_WIDTH, 11, instruction-memory byte-address width, matching the core's fetch address width
- P_DATA_WIDTH, 32, instruction word width
- i_clk  in  1  clock; all logic is on the rising edge
- i_rst_n  in  1  reset, asynchronous and active-low; one clock domain
- i_start_load  in  1  single-cycle pulse that starts a new load from any state
- i_run  in  1  single-cycle pulse that releases the core without loading; honoured only in IDLE
- i_rx_valid  in  1  host byte valid
- i_rx_data  in  8  host byte
- o_rx_ready  out  1  byte accept; a transfer occurs when i_rx_valid and o_rx_ready are both 1
- o_imem_we  out  1  instruction-memory write strobe, one cycle per word
- o_imem_waddr  out  P_ADDR_WIDTH  byte address of the write, always word-aligned
- o_imem_wdata  out  P_DATA_WIDTH  assembled instruction word
- o_core_rst_n  out  1  core reset, active-low, registered
- o_busy  out  1  high in HDR0, HDR1, PAYLOAD and CKSUM
- o_done  out  1  high in RUN
- o_err  out  1  high in ERROR

## Operation
- Frame format: count_lo, count_hi, then count×4 payload bytes (little-endian, LSB first), then one checksum byte.
- count is a 16-bit word count.
- The checksum is the XOR of all payload bytes only; the count bytes are excluded.
- States: IDLE, HDR0, HDR1, PAYLOAD, CKSUM, RUN, ERROR.
- IDLE:
  - i_start_load moves to HDR0.
  - i_run moves to RUN.
  - If both pulse in the same cycle, i_start_load wins.
- HDR0: accept count_lo, then go to HDR1.
- HDR1: accept count_hi. Decide the next state as follows:
  - count > 2^(P_ADDR_WIDTH-2): go to ERROR (overflow).
  - count == 0: go to CKSUM.
  - otherwise: go to PAYLOAD.
  - Clear the word index, byte index and running checksum on entry.
- PAYLOAD:
  - Each accepted byte goes into lane byte_idx of the word buffer and is XORed into the running checksum.
  - On the 4th byte, the next cycle drives o_imem_we=1 with o_imem_waddr = word_idx×4 and o_imem_wdata = the full word.
  - word_idx increments and byte_idx wraps to 0.
  - After word count-1 is accepted, go to CKSUM.
- CKSUM: accept one byte.
  - If it matches the running checksum, go to RUN.
  - Otherwise go to ERROR.
- RUN: o_core_rst_n=1. i_start_load re-enters HDR0 and asserts core reset again.
- ERROR: core stays held in reset. Only i_start_load (to HDR0) or i_rst_n exits. i_run is ignored.
- i_start_load in any busy state aborts the current frame, restarts at HDR0 and clears the indices and checksum. Words already written stay in memory.
- o_rx_ready is 1 in busy states only. In IDLE, RUN and ERROR, bytes are not consumed.
- An i_rx_valid gap of any length stalls the FSM with no side effects.

## Timing
- Reset values:
  - state = IDLE
  - o_core_rst_n = 0
  - o_imem_we = 0
  - o_imem_waddr = 0
  - o_imem_wdata = 0
  - o_rx_ready = 0
  - o_busy = 0
  - o_done = 0
  - o_err = 0
- o_rx_ready, o_busy, o_done and o_err decode from the registered state. They change the cycle after the transition edge.
- Write latency: o_imem_we is high for exactly one cycle, the cycle after the edge that accepts the 4th byte. Address and data are stable that cycle.
- Throughput: one byte per cycle when i_rx_valid is held high. Back-to-back words give one write every 4 cycles.
- o_core_rst_n:
  - Rises on the edge after the matching checksum byte is accepted, i.e. one cycle after acceptance.
  - The last o_imem_we always precedes or coincides with that cycle. The core's first fetch (≥1 cycle later) sees the full image.
  - Falls on the edge after i_start_load is sampled in RUN.
- Simultaneous events: i_start_load in the same cycle as a byte transfer restarts the frame and discards that byte. No write is issued for a partial word.
- Asynchronous reset mid-load: all outputs go to their reset values immediately, and o_imem_we drops in the same instant.

## Test plan
- Nominal load:
  - Stimulus: pulse i_start_load, then stream 02 00 93 00 50 00 13 00 00 00 D0.
  - Required: writes (addr 0x000, data 0x00500093) and (addr 0x004, data 0x00000013); o_core_rst_n=1 one cycle after D0 is accepted; o_done=1.
- Bad checksum: same frame ending in D1 -> no RUN; o_err=1; o_core_rst_n stays 0; both words are still written.
- Zero and overflow counts:
  - Stream 00 00 00 -> RUN with no writes.
  - With P_ADDR_WIDTH=11, count 01 02 (0x201) -> ERROR directly after count_hi, and no bytes are consumed after it.
- Backpressure and gaps: nominal frame with i_rx_valid toggled randomly -> identical writes and checksum result; exactly 2 o_imem_we pulses.
- Reload and abort:
  - In RUN, pulse i_start_load -> o_core_rst_n=0 next cycle and o_busy=1.
  - Pulse i_start_load again after 2 payload bytes -> indices reset, and the new frame writes from addr 0x000.
- Reset mid-payload: assert i_rst_n=0 while o_imem_we=1 -> outputs are at reset values immediately; after release, state is IDLE and i_run alone gives o_core_rst_n=1.

Source files
------------

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl
//   Boot / program-load controller. Holds the core in reset, takes a framed
//   byte stream (count_lo, count_hi, count*4 payload bytes LSB-first, XOR
//   checksum byte), writes assembled 32-bit words into instruction memory and
//   releases the core only when the checksum matches.
// Ports
//   i_clk, i_rst_n        clock, async active-low reset
//   i_start_load          pulse: (re)start a load from any state
//   i_run                 pulse: release the core without loading (IDLE only)
//   i_rx_valid/i_rx_data  host byte stream; o_rx_ready accepts
//   o_imem_we/waddr/wdata instruction-memory write port (one pulse per word)
//   o_core_rst_n          core reset, active-low, registered
//   o_busy/o_done/o_err   status decoded from the registered state
module imem_loader_ctrl #(
   parameter int P_ADDR_WIDTH = 11,
   parameter int P_DATA_WIDTH = 32
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start_load,
   input  logic                    i_run,
   input  logic                    i_rx_valid,
   input  logic [7:0]              i_rx_data,
   output logic                    o_rx_ready,
   output logic                    o_imem_we,
   output logic [P_ADDR_WIDTH-1:0] o_imem_waddr,
   output logic [P_DATA_WIDTH-1:0] o_imem_wdata,
   output logic                    o_core_rst_n,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_err
);

   typedef enum logic [2:0] {
      S_IDLE, S_HDR0, S_HDR1, S_PAYLOAD, S_CKSUM, S_RUN, S_ERROR
   } state_t;

   // Largest word count that fits the memory; compared at 17 bits so a full
   // 16-bit count never wraps.
   localparam logic [16:0] MAX_WORDS = 17'(1) << (P_ADDR_WIDTH - 2);

   state_t      state;
   logic [7:0]  count_lo;
   logic [15:0] count;
   logic [15:0] word_idx;
   logic [1:0]  byte_idx;
   logic [7:0]  cksum;
   logic [23:0] word_buf;   // lanes 0..2; lane 3 comes straight off the bus
   logic        xfer;
   logic [15:0] count_rx;

   assign o_busy     = (state == S_HDR0) || (state == S_HDR1) ||
                       (state == S_PAYLOAD) || (state == S_CKSUM);
   assign o_rx_ready = o_busy;
   assign o_done     = (state == S_RUN);
   assign o_err      = (state == S_ERROR);

   assign xfer     = i_rx_valid && o_rx_ready;
   assign count_rx = {i_rx_data, count_lo};

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= S_IDLE;
         count_lo     <= '0;
         count        <= '0;
         word_idx     <= '0;
         byte_idx     <= '0;
         cksum        <= '0;
         word_buf     <= '0;
         o_imem_we    <= 1'b0;
         o_imem_waddr <= '0;
         o_imem_wdata <= '0;
         o_core_rst_n <= 1'b0;
      end else begin
         o_imem_we <= 1'b0;
         // Start has priority over everything, including a byte offered in
         // the same cycle: that byte is dropped and no partial word is written.
         if (i_start_load) begin
            state        <= S_HDR0;
            o_core_rst_n <= 1'b0;
            word_idx     <= '0;
            byte_idx     <= '0;
            cksum        <= '0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (i_run) begin
                     state        <= S_RUN;
                     o_core_rst_n <= 1'b1;
                  end
               end
               S_HDR0: begin
                  if (xfer) begin
                     count_lo <= i_rx_data;
                     state    <= S_HDR1;
                  end
               end
               S_HDR1: begin
                  if (xfer) begin
                     count    <= count_rx;
                     word_idx <= '0;
                     byte_idx <= '0;
                     cksum    <= '0;
                     if ({1'b0, count_rx} > MAX_WORDS) state <= S_ERROR;
                     else if (count_rx == 16'd0)      state <= S_CKSUM;
                     else                             state <= S_PAYLOAD;
                  end
               end
               S_PAYLOAD: begin
                  if (xfer) begin
                     cksum    <= cksum ^ i_rx_data;
                     byte_idx <= byte_idx + 2'd1;
                     case (byte_idx)
                        2'd0: word_buf[7:0]   <= i_rx_data;
                        2'd1: word_buf[15:8]  <= i_rx_data;
                        2'd2: word_buf[23:16] <= i_rx_data;
                        default: begin
                           o_imem_we    <= 1'b1;
                           o_imem_waddr <= {word_idx[P_ADDR_WIDTH-3:0], 2'b00};
                           o_imem_wdata <= P_DATA_WIDTH'({i_rx_data, word_buf});
                           word_idx     <= word_idx + 16'd1;
                           if (word_idx == count - 16'd1) state <= S_CKSUM;
                        end
                     endcase
                  end
               end
               S_CKSUM: begin
                  if (xfer) begin
                     if (i_rx_data == cksum) begin
                        state        <= S_RUN;
                        o_core_rst_n <= 1'b1;
                     end else begin
                        state <= S_ERROR;
                     end
                  end
               end
               default: ;  // RUN / ERROR leave only via start or reset
            endcase
         end
      end
   end

endmodule

// File: tb/tb_imem_loader_ctrl.sv
module tb_imem_loader_ctrl;
   localparam int AW = 11;
   localparam int DW = 32;

   logic          i_clk = 1'b0;
   logic          i_rst_n = 1'b0;
   logic          i_start_load = 1'b0;
   logic          i_run = 1'b0;
   logic          i_rx_valid = 1'b0;
   logic [7:0]    i_rx_data = 8'h00;
   logic          o_rx_ready;
   logic          o_imem_we;
   logic [AW-1:0] o_imem_waddr;
   logic [DW-1:0] o_imem_wdata;
   logic          o_core_rst_n;
   logic          o_busy;
   logic          o_done;
   logic          o_err;

   int vectors = 0;
   int miscompares = 0;

   logic [AW-1:0] wa_q[$];
   logic [DW-1:0] wd_q[$];

   imem_loader_ctrl #(.P_ADDR_WIDTH(AW), .P_DATA_WIDTH(DW)) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_start_load(i_start_load), .i_run(i_run),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
      .o_imem_we(o_imem_we), .o_imem_waddr(o_imem_waddr), .o_imem_wdata(o_imem_wdata),
      .o_core_rst_n(o_core_rst_n), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
   );

   always #5 i_clk = ~i_clk;

   // Record every write pulse, sampled mid-cycle.
   always @(negedge i_clk) begin
      if (i_rst_n && o_imem_we) begin
         wa_q.push_back(o_imem_waddr);
         wd_q.push_back(o_imem_wdata);
      end
   end

   task automatic tick();
      @(posedge i_clk); #1;
   endtask

   // Offer one byte (after 'gap' idle cycles) and return #1 after the edge
   // that accepted it. Valid stays high so back-to-back calls stream.
   task automatic send_byte(input logic [7:0] b, input int gap);
      bit rdy;
      int n;
      repeat (gap) begin i_rx_valid = 1'b0; tick(); end
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      n = 0;
      do begin
         @(negedge i_clk); rdy = o_rx_ready;
         tick();
         n++;
      end while (!rdy && n < 50);
      if (!rdy) begin
         vectors++; miscompares++;
         $display("FAIL accept_timeout byte=%02h not accepted within 50 cycles", b);
      end
   endtask

   task automatic send_stream(input logic [7:0] s[$], input bit gaps);
      for (int i = 0; i < s.size(); i++)
         send_byte(s[i], gaps ? ((i * 7 + 3) % 4) : 0);
      i_rx_valid = 1'b0;
   endtask

   task automatic pulse_start();
      i_start_load = 1'b1; tick(); i_start_load = 1'b0;
   endtask

   task automatic pulse_run();
      i_run = 1'b1; tick(); i_run = 1'b0;
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      repeat (2) tick();
      vectors++; if (o_core_rst_n !== 1'b0) begin miscompares++; $display("FAIL rst_core got=%b exp=0", o_core_rst_n); end
      vectors++; if (o_imem_we !== 1'b0) begin miscompares++; $display("FAIL rst_we got=%b exp=0", o_imem_we); end
      vectors++; if (o_imem_waddr !== '0) begin miscompares++; $display("FAIL rst_waddr got=%h exp=0", o_imem_waddr); end
      vectors++; if (o_imem_wdata !== '0) begin miscompares++; $display("FAIL rst_wdata got=%h exp=0", o_imem_wdata); end
      vectors++; if ({o_rx_ready, o_busy, o_done, o_err} !== 4'b0000) begin
         miscompares++; $display("FAIL rst_status got=%b exp=0000", {o_rx_ready, o_busy, o_done, o_err}); end
      i_rst_n = 1'b1;
      tick();
      vectors++; if (o_rx_ready !== 1'b0) begin miscompares++; $display("FAIL idle_ready got=%b exp=0", o_rx_ready); end
   endtask

   task automatic check_nominal_writes(input string tag);
      vectors++; if (wa_q.size() !== 2) begin miscompares++; $display("FAIL %s_nwr got=%0d exp=2", tag, wa_q.size()); end
      else begin
         vectors++; if (wa_q[0] !== 11'h000 || wd_q[0] !== 32'h00500093) begin miscompares++;
            $display("FAIL %s_wr0 got=%h/%h exp=000/00500093", tag, wa_q[0], wd_q[0]); end
         vectors++; if (wa_q[1] !== 11'h004 || wd_q[1] !== 32'h00000013) begin miscompares++;
            $display("FAIL %s_wr1 got=%h/%h exp=004/00000013", tag, wa_q[1], wd_q[1]); end
      end
   endtask

   task automatic test_nominal();
      logic [7:0] s[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      vectors++; if (o_busy !== 1'b1) begin miscompares++; $display("FAIL nom_busy got=%b exp=1", o_busy); end
      send_stream(s, 1'b0);
      vectors++; if (o_core_rst_n !== 1'b0) begin miscompares++; $display("FAIL nom_core_pre got=%b exp=0", o_core_rst_n); end
      send_byte(8'hD0, 0); i_rx_valid = 1'b0;
      vectors++; if (o_core_rst_n !== 1'b1 || o_done !== 1'b1) begin miscompares++;
         $display("FAIL nom_run core=%b done=%b exp=1/1", o_core_rst_n, o_done); end
      vectors++; if (o_rx_ready !== 1'b0) begin miscompares++; $display("FAIL nom_run_ready got=%b exp=0", o_rx_ready); end
      repeat (2) tick();
      check_nominal_writes("nom");
   endtask

   task automatic test_bad_cksum();
      logic [7:0] s[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD1};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      vectors++; if (o_core_rst_n !== 1'b0 || o_busy !== 1'b1) begin miscompares++;
         $display("FAIL reload core=%b busy=%b exp=0/1", o_core_rst_n, o_busy); end
      send_stream(s, 1'b0);
      vectors++; if (o_err !== 1'b1 || o_done !== 1'b0 || o_core_rst_n !== 1'b0) begin miscompares++;
         $display("FAIL bad_ck err=%b done=%b core=%b exp=1/0/0", o_err, o_done, o_core_rst_n); end
      repeat (2) tick();
      check_nominal_writes("bad");
      pulse_run();
      tick();
      vectors++; if (o_err !== 1'b1 || o_core_rst_n !== 1'b0) begin miscompares++;
         $display("FAIL err_run_ignored err=%b core=%b exp=1/0", o_err, o_core_rst_n); end
   endtask

   task automatic test_zero_overflow();
      logic [7:0] z[$]  = '{8'h00, 8'h00, 8'h00};
      logic [7:0] ov[$] = '{8'h01, 8'h02};
      logic [7:0] mx[$] = '{8'h00, 8'h02};
      int acc;
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_stream(z, 1'b0);
      vectors++; if (o_done !== 1'b1 || o_core_rst_n !== 1'b1) begin miscompares++;
         $display("FAIL zero_run done=%b core=%b exp=1/1", o_done, o_core_rst_n); end
      tick();
      vectors++; if (wa_q.size() !== 0) begin miscompares++; $display("FAIL zero_nwr got=%0d exp=0", wa_q.size()); end
      // count 0x201 exceeds 512 words
      pulse_start();
      send_stream(ov, 1'b0);
      vectors++; if (o_err !== 1'b1 || o_rx_ready !== 1'b0) begin miscompares++;
         $display("FAIL ovf err=%b ready=%b exp=1/0", o_err, o_rx_ready); end
      acc = 0;
      i_rx_valid = 1'b1; i_rx_data = 8'h55;
      repeat (4) begin @(negedge i_clk); if (o_rx_ready) acc++; tick(); end
      i_rx_valid = 1'b0;
      vectors++; if (acc !== 0) begin miscompares++; $display("FAIL ovf_consume got=%0d exp=0", acc); end
      // count 0x200 exactly fills memory: accepted
      pulse_start();
      send_stream(mx, 1'b0);
      vectors++; if (o_busy !== 1'b1 || o_err !== 1'b0) begin miscompares++;
         $display("FAIL max_count busy=%b err=%b exp=1/0", o_busy, o_err); end
   endtask

   task automatic test_gaps();
      logic [7:0] s[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD0};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_stream(s, 1'b1);
      vectors++; if (o_done !== 1'b1 || o_core_rst_n !== 1'b1) begin miscompares++;
         $display("FAIL gap_run done=%b core=%b exp=1/1", o_done, o_core_rst_n); end
      repeat (2) tick();
      check_nominal_writes("gap");
   endtask

   task automatic test_abort();
      logic [7:0] p[$] = '{8'h02, 8'h00, 8'h77, 8'h66};
      logic [7:0] s[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'hD0};
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_stream(p, 1'b0);
      // restart with a byte offered in the same cycle: that byte is dropped
      i_rx_valid = 1'b1; i_rx_data = 8'hAA;
      pulse_start();
      i_rx_valid = 1'b0;
      send_stream(s, 1'b0);
      vectors++; if (o_done !== 1'b1) begin miscompares++; $display("FAIL abort_run done=%b exp=1", o_done); end
      repeat (2) tick();
      check_nominal_writes("abort");
   endtask

   task automatic test_reset_mid();
      logic [7:0] s[$] = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50};
      pulse_start();
      send_stream(s, 1'b0);
      send_byte(8'h00, 0); i_rx_valid = 1'b0;
      vectors++; if (o_imem_we !== 1'b1) begin miscompares++; $display("FAIL mid_we got=%b exp=1", o_imem_we); end
      i_rst_n = 1'b0;
      #1;
      vectors++; if (o_imem_we !== 1'b0 || o_imem_waddr !== '0 || o_imem_wdata !== '0) begin miscompares++;
         $display("FAIL mid_rst_wr we=%b addr=%h data=%h exp=0/0/0", o_imem_we, o_imem_waddr, o_imem_wdata); end
      vectors++; if ({o_core_rst_n, o_busy, o_done, o_err, o_rx_ready} !== 5'b00000) begin miscompares++;
         $display("FAIL mid_rst_status got=%b exp=00000", {o_core_rst_n, o_busy, o_done, o_err, o_rx_ready}); end
      tick();
      i_rst_n = 1'b1;
      tick();
      pulse_run();
      vectors++; if (o_core_rst_n !== 1'b1 || o_done !== 1'b1) begin miscompares++;
         $display("FAIL mid_run core=%b done=%b exp=1/1", o_core_rst_n, o_done); end
   endtask

   task automatic test_start_run_same();
      i_rst_n = 1'b0; tick(); i_rst_n = 1'b1; tick();
      i_start_load = 1'b1; i_run = 1'b1; tick(); i_start_load = 1'b0; i_run = 1'b0;
      vectors++; if (o_busy !== 1'b1 || o_done !== 1'b0) begin miscompares++;
         $display("FAIL start_wins busy=%b done=%b exp=1/0", o_busy, o_done); end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_cksum();
      test_zero_overflow();
      test_gaps();
      test_abort();
      test_reset_mid();
      test_start_run_same();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end
endmodule
